// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: table entry layout, FSM states
// and the placement of period_code within the flasher reload word.
package led_seq_pkg;

    typedef struct packed {
        logic [15:0] dwell;
        logic [7:0]  period_code;
        logic [7:0]  pattern;
    } led_seq_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } led_seq_state_t;

    localparam int FLASH_SHIFT = 16;

    function automatic logic [31:0] flash_word(input logic [7:0] period_code);
        return {24'h000000, period_code} << FLASH_SHIFT;
    endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Dwell prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap cycle.
// Held at zero when disabled or cleared so every entry starts a fresh tick period.
module led_seq_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tick must not depend on clear: clear is derived from tick one level up
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/led_sequencer.sv
// Programmable LED pattern sequencer feeding the per-LED flasher stage.
// Steps a register-loaded table with per-entry dwell; all outputs registered.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [31:0]              cfg_wdata,
    input  logic [$clog2(DEPTH)-1:0] cfg_last,
    input  logic                     cfg_loop,
    input  logic                     start,
    input  logic                     stop,
    output logic [NUM_LEDS-1:0]      led_state,
    output logic [31:0]              flash_counter,
    output logic [$clog2(DEPTH)-1:0] cur_index,
    output logic                     busy,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);

    led_seq_entry_t table_q [DEPTH];

    led_seq_state_t state_q, state_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [31:0]         flash_q, flash_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [15:0]         dwell_q, dwell_d;
    logic [15:0]         dcnt_q, dcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic           tick;
    logic           entry_end;
    logic           load;
    logic [AW-1:0]  load_idx;
    led_seq_entry_t ld_entry;

    always_ff @(posedge clock) begin
        if (cfg_we) begin
            table_q[cfg_addr] <= led_seq_entry_t'(cfg_wdata);
        end
    end

    led_seq_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clock (clock),
        .reset (reset),
        .en    (state_q == RUN),
        .clear (load),
        .tick  (tick)
    );

    // dwell_q is never 0 in RUN, so dwell_q-1 is the last dwell count
    assign entry_end = tick && (dcnt_q == dwell_q - 16'd1);
    assign ld_entry  = table_q[load_idx];

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_idx = '0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    load = 1'b1;
                end else if (entry_end) begin
                    if (idx_q != cfg_last) begin
                        load     = 1'b1;
                        load_idx = idx_q + 1'b1;
                    end else if (cfg_loop) begin
                        load = 1'b1;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                if (start && !stop) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        led_d   = led_q;
        flash_d = flash_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        dcnt_d  = dcnt_q;
        if (load) begin
            led_d   = ld_entry.pattern[NUM_LEDS-1:0];
            flash_d = flash_word(ld_entry.period_code);
            idx_d   = load_idx;
            dwell_d = (ld_entry.dwell == 16'd0) ? 16'd1 : ld_entry.dwell;
            dcnt_d  = '0;
        end else if (state_d != RUN) begin
            led_d   = '0;
            flash_d = '0;
            idx_d   = '0;
            dcnt_d  = '0;
        end else if (tick) begin
            dcnt_d = dcnt_q + 16'd1;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            led_q   <= '0;
            flash_q <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            flash_q <= flash_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign led_state     = led_q;
    assign flash_counter = flash_q;
    assign cur_index     = idx_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with TICK_DIV=4: stimulus queues one
// expected record per busy cycle, a negedge monitor pops and compares them.
module tb_led_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [2:0]  cfg_last = '0;
    logic        cfg_loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  led_state;
    logic [31:0] flash_counter;
    logic [2:0]  cur_index;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q[$];

    led_sequencer #(
        .NUM_LEDS (8),
        .DEPTH    (8),
        .TICK_DIV (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_last      (cfg_last),
        .cfg_loop      (cfg_loop),
        .start         (start),
        .stop          (stop),
        .led_state     (led_state),
        .flash_counter (flash_counter),
        .cur_index     (cur_index),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] rec(input logic [7:0] led, input logic [7:0] per,
                                        input logic [2:0] idx, input logic d);
        return {20'h0, led, 8'h00, per, 16'h0000, idx, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] led, input logic [7:0] per,
                        input logic [2:0] idx, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(rec(led, per, idx, 1'b0));
    endtask

    task automatic push_done();
        exp_q.push_back(rec(8'h00, 8'h00, 3'd0, 1'b1));
    endtask

    // Each busy cycle must match the next queued record.
    always @(negedge clock) begin
        if (busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL extra_busy_cycle: got led=%h flash=%h idx=%0d done=%b want no busy",
                         led_state, flash_counter, cur_index, done);
            end else begin
                chk("busy_cycle", {20'h0, led_state, flash_counter, cur_index, done},
                    exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [15:0] dwell,
                      input logic [7:0] per, input logic [7:0] pat);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = {dwell, per, pat};
        cyc(1);
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic chk_idle(input string name);
        chk(name, {19'h0, led_state, flash_counter, cur_index, busy, done}, 64'h0);
    endtask

    task automatic finish_check(input string name);
        int k = 0;
        while (busy === 1'b1 && k < 80) begin
            @(negedge clock);
            k++;
        end
        chk({name, "_terminates"}, {63'h0, busy}, 64'h0);
        #1;
        chk({name, "_drain"}, 64'(exp_q.size()), 64'h0);
        exp_q.delete();
        chk_idle({name, "_idle"});
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        cyc(2);
        reset = 1'b0;
        chk_idle("reset_state");

        wr(3'd0, 16'd2, 8'h03, 8'h81);
        wr(3'd1, 16'd1, 8'h10, 8'h3C);
        cfg_last = 3'd1;

        // Single pass then done
        cfg_loop = 1'b0;
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'h3C, 8'h10, 3'd1, 4);
        push_done();
        pulse_start();
        finish_check("single_pass");

        // Loop: 0,1,0,1 then stop on the first cycle of the third e0
        cfg_loop = 1'b1;
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'h3C, 8'h10, 3'd1, 4);
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'h3C, 8'h10, 3'd1, 4);
        push(8'h81, 8'h03, 3'd0, 1);
        pulse_start();
        cyc(24);
        pulse_stop();
        finish_check("loop_stop");
        cfg_loop = 1'b0;

        // dwell 0 behaves as dwell 1
        wr(3'd0, 16'd0, 8'h03, 8'h81);
        push(8'h81, 8'h03, 3'd0, 4);
        push(8'h3C, 8'h10, 3'd1, 4);
        push_done();
        pulse_start();
        finish_check("dwell_zero");
        wr(3'd0, 16'd2, 8'h03, 8'h81);

        // Stop three cycles into e0: no done
        push(8'h81, 8'h03, 3'd0, 3);
        pulse_start();
        cyc(2);
        pulse_stop();
        chk_idle("stop_next_cycle");
        start = 1'b1;
        stop  = 1'b1;
        cyc(1);
        start = 1'b0;
        stop  = 1'b0;
        chk_idle("start_stop_same_cycle");
        finish_check("stop_case");

        // Restart during e1 gives a full e0 dwell
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'h3C, 8'h10, 3'd1, 2);
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'h3C, 8'h10, 3'd1, 4);
        push_done();
        pulse_start();
        cyc(9);
        pulse_start();
        finish_check("restart");

        // Rewrite e1 while e0 is displayed
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'hA5, 8'h55, 3'd1, 12);
        push_done();
        pulse_start();
        cyc(2);
        wr(3'd1, 16'd3, 8'h55, 8'hA5);
        finish_check("live_write");

        // Reset mid-run keeps the table
        push(8'h81, 8'h03, 3'd0, 1);
        pulse_start();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk_idle("reset_mid_run");
        finish_check("reset_case");
        push(8'h81, 8'h03, 3'd0, 8);
        push(8'hA5, 8'h55, 3'd1, 12);
        push_done();
        pulse_start();
        finish_check("retained_table");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
